// File: rtl/output_path_reader_if.sv
// Byte stream from the output path reader to the host/UART/checker stage.
// Plain valid/ready: a beat transfers on any edge where out_valid && out_ready.
interface output_path_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/output_path_reader.sv
// Walks the Output Memory from base_addr and streams bytes until terminator or MAX_COUNT.
// Latency: start -> first out_valid 2 cycles; 1 beat/cycle with out_ready held high.
// Backpressure: out_ready low freezes out_data, address, count and out_last; nothing is dropped.
module output_path_reader #(
    parameter int                    ADDR_WIDTH = 13,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] TERMINATOR = 8'hFF,
    parameter int                    MAX_COUNT  = 8191
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic [ADDR_WIDTH-1:0] OMAR,
    input  logic [DATA_WIDTH-1:0] OMDR,
    output_path_reader_if.master  strm,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        FINISH  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MAX_COUNT - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_c, last_c, busy_c, done_c;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        data_d  = data_q;
        valid_c = 1'b0;
        last_c  = 1'b0;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    count_d = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                busy_c = 1'b1;
                if (OMDR == TERMINATOR) begin
                    state_d = FINISH;
                end else begin
                    data_d  = OMDR;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                busy_c  = 1'b1;
                valid_c = 1'b1;
                // OMDR here is the lookahead byte after the one being presented
                last_c  = (OMDR == TERMINATOR) || (count_q == LAST_IDX);
                if (strm.out_ready) begin
                    count_d = count_q + ADDR_WIDTH'(1);
                    if (last_c) begin
                        state_d = FINISH;
                    end else begin
                        data_d = OMDR;
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            FINISH: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign OMAR           = addr_q;
    assign count          = count_q;
    assign busy           = busy_c;
    assign done           = done_c;
    assign strm.out_data  = data_q;
    assign strm.out_valid = valid_c;
    assign strm.out_last  = last_c;

endmodule

// File: doc/output_path_reader.md
# output_path_reader

Sequential reader for the Output Memory (SRAM_1R1W, 13-bit address, 8-bit data, combinational read port) that `bellmanford` fills with result bytes. On a start pulse it walks the memory from a base address and streams each byte out over a valid/ready handshake. It stops at a terminator byte or after a maximum count, then signals completion. It sits on the OMAR/OMDR read port after `bellmanford` has finished writing, and feeds a host/UART/checker stage.

## Interface
- ADDR_WIDTH, 13: Output Memory address width.
- DATA_WIDTH, 8: Output Memory data width.
- TERMINATOR, 8'hFF: end-of-result marker. Never emitted on the stream.
- MAX_COUNT, 8191: maximum beats per run, 1..2^ADDR_WIDTH-1.

- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first address to read; sampled with start.
- OMAR  out  ADDR_WIDTH  Output Memory read address.
- OMDR  in  DATA_WIDTH  Output Memory read data, combinational from OMAR.
- out_data  out  DATA_WIDTH  stream byte.
- out_valid  out  1  out_data/out_last are valid.
- out_ready  in  1  downstream accepts the current beat.
- out_last  out  1  current beat is the final beat of the run.
- busy  out  1  high in FETCH and PRESENT.
- done  out  1  one-cycle pulse at end of run.
- count  out  ADDR_WIDTH  beats accepted in the current/last run.

## Operation
- Internal registers: state, addr, out_data, count.
- OMAR = addr in every state.
- **IDLE**
  - On start: addr <= base_addr, count <= 0, go to FETCH.
  - start while not IDLE is ignored and has no side effects.
- **FETCH** (exactly 1 cycle)
  - If OMDR == TERMINATOR: go to DONE. This is a zero-length run: no beats, count stays 0.
  - Otherwise: out_data <= OMDR, addr <= addr+1, go to PRESENT.
- **PRESENT**
  - out_valid = 1. OMAR points at the byte after the presented one (lookahead).
  - out_last = (OMDR == TERMINATOR) || (count == MAX_COUNT-1). Combinational from the lookahead byte.
  - On out_valid && out_ready: count <= count+1.
    - If out_last: go to DONE.
    - Otherwise: out_data <= OMDR, addr <= addr+1, stay in PRESENT.
  - While out_ready = 0: out_data, addr, count and therefore OMAR and out_last stay constant.
- **DONE** (1 cycle): done = 1, then go to IDLE. count holds until the next accepted start.
- Address arithmetic is modulo 2^ADDR_WIDTH: 8191+1 wraps to 0. A run may cross the wrap.
- System rule: the Output Memory is not written (OMWE low) while busy. The block does not check this.
- The terminator is consumed, not streamed. A run stopped by MAX_COUNT does not read past the last beat's lookahead byte.
- **reset** (synchronous, any state, including mid-beat with out_valid high): state <= IDLE, addr <= 0, count <= 0, out_data <= 0. The pending beat is dropped.

## Timing
- Reset values: OMAR = 0, out_data = 0, out_valid = 0, out_last = 0, busy = 0, done = 0, count = 0.
- start at edge k → FETCH during cycle k+1 → first out_valid in cycle k+2 (2-cycle latency).
- Throughput: 1 beat/cycle with out_ready held high.
- Last accepted beat at edge j → done high in cycle j+1 → IDLE in cycle j+2. The earliest next start is sampled at edge j+2.
- Zero-length run: start at k → done high in cycle k+2, out_valid never asserted.
- out_valid never drops without a handshake, except under reset.

## Test plan
- Memory[0x010..0x014] = 03 07 01 0A FF; start, base 0x010; out_ready = 1 → beats 03, 07, 01, 0A on consecutive cycles; out_last only on 0A; done one cycle later; count = 4.
- Same data; out_ready toggles 1,0,0,1,… → out_data and out_last stable during stalls; same 4 beats in order; count = 4.
- Memory[0x020] = FF; start, base 0x020 → no out_valid; done in cycle k+2; count = 0.
- Memory[0x1FFE] = 05, [0x1FFF] = 06, [0x0000] = 09, [0x0001] = FF; base 0x1FFE → beats 05, 06, 09; OMAR wraps to 0x0000; count = 3.
- MAX_COUNT = 4; memory 01 02 03 04 05 06 with no terminator → beats 01..04, out_last on 04, count = 4, done.
- Assert reset while stalled on the 2nd beat → next cycle out_valid = 0, busy = 0, count = 0. A fresh start then replays the run from base.
